// File: rtl/nibble_serial_adder_ctrl.sv
// Serial WIDTH-bit adder: one 4-bit ripple adder is reused over WIDTH/4 cycles,
// least-significant nibble first, with valid/ready handshakes on both sides.

module ripple_adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c0,
  output logic [3:0] s,
  output logic       c4
);
  logic [4:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = c0;
    for (int i = 0; i < 4; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    c4 = c[4];
  end
endmodule

module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);
  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             c_q;
  logic [IW-1:0]    idx;
  logic [3:0]       nib_a, nib_b, nib_s;
  logic             nib_c4;

  // Operand nibble mux built from constant slices so every select stays in range.
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int i = 0; i < N; i++) begin
      if (idx == IW'(i)) begin
        nib_a = a_q[4*i +: 4];
        nib_b = b_q[4*i +: 4];
      end
    end
  end

  ripple_adder_4bit u_adder (
    .a  (nib_a),
    .b  (nib_b),
    .c0 (c_q),
    .s  (nib_s),
    .c4 (nib_c4)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)      state_next = RUN;
      RUN:     if (idx == LAST)   state_next = DONE;
      DONE:    if (out_ready)     state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // The carry register is the only link between nibbles, so the combinational
  // path never exceeds one 4-bit ripple plus the operand mux.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= 1'b0;
      idx   <= '0;
      sum_q <= '0;
    end else if (state == IDLE && in_valid) begin
      a_q   <= in_a;
      b_q   <= in_b;
      c_q   <= in_cin;
      idx   <= '0;
      sum_q <= '0;
    end else if (state == RUN) begin
      for (int i = 0; i < N; i++) begin
        if (idx == IW'(i)) sum_q[4*i +: 4] <= nib_s;
      end
      c_q <= nib_c4;
      if (idx != LAST) idx <= idx + 1'b1;
    end
  end

  assign out_sum  = sum_q;
  assign out_cout = c_q;
endmodule
